// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the clock front-end and the count_* blocks.
//   MODE_*  : 2-bit select_mode encoding (run / adjust sec / min / hour)
//   mode_e  : enum view of the same encoding for the mode FSM
//   next_mode(): mode sequence RUN -> SEC -> MIN -> HOUR -> RUN
// -----------------------------------------------------------------------------
package clock_pkg;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_SEC  = 2'b01;
    localparam logic [1:0] MODE_MIN  = 2'b10;
    localparam logic [1:0] MODE_HOUR = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN  = MODE_RUN,
        ST_SEC  = MODE_SEC,
        ST_MIN  = MODE_MIN,
        ST_HOUR = MODE_HOUR
    } mode_e;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            ST_RUN:  return ST_SEC;
            ST_SEC:  return ST_MIN;
            ST_MIN:  return ST_HOUR;
            default: return ST_RUN;
        endcase
    endfunction

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// -----------------------------------------------------------------------------
// clock_mode_ctrl_if
// Button pins in, counter-control levels out.
//   btn_mode_n / btn_up_n / btn_dw_n : raw active-low buttons (async)
//   select_mode                      : current mode (clock_pkg encoding)
//   ena_up / ena_dw                  : active-low adjust request levels
// Modports: master = board/bench side, slave = clock_mode_ctrl.
// -----------------------------------------------------------------------------
interface clock_mode_ctrl_if;
    logic       btn_mode_n;
    logic       btn_up_n;
    logic       btn_dw_n;
    logic [1:0] select_mode;
    logic       ena_up;
    logic       ena_dw;

    modport master (
        output btn_mode_n, btn_up_n, btn_dw_n,
        input  select_mode, ena_up, ena_dw
    );

    modport slave (
        input  btn_mode_n, btn_up_n, btn_dw_n,
        output select_mode, ena_up, ena_dw
    );
endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser followed by a stable-level debouncer for one
// active-low push-button.
//   clk, rst_n : clock, synchronous active-low reset
//   btn_n      : raw asynchronous button, low = pressed
//   stable_n   : debounced level, 1 = released (reset value)
//   press      : one-cycle pulse on the debounced 1->0 edge
// A new level is accepted once it has differed from stable_n for DEB_CYCLES
// consecutive cycles; any return to the old level restarts the count.
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic stable_n,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        press_d = stable_q & ~stable_d;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_n;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_n = stable_q;
    assign press    = press_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// -----------------------------------------------------------------------------
// clock_mode_ctrl
// Button front-end for the hour/min/sec counters: debounces mode/up/down,
// steps the mode FSM, drives the registered active-low adjust levels and
// falls back to run mode after an idle timeout in any adjust mode.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : clock_mode_ctrl_if.slave (buttons in, select_mode/ena_* out)
// All outputs come straight from flops because the counters derive clocks
// from them.
// -----------------------------------------------------------------------------
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int DEB_CYCLES  = 500000,
    parameter int IDLE_CYCLES = 1500000000
) (
    input  logic             clk,
    input  logic             rst_n,
    clock_mode_ctrl_if.slave bus
);

    localparam int IW = $clog2(IDLE_CYCLES + 1);

    logic mode_press, up_press, dw_press;
    logic up_stable_n, dw_stable_n;
    logic mode_stable_unused;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk(clk), .rst_n(rst_n), .btn_n(bus.btn_mode_n),
        .stable_n(mode_stable_unused), .press(mode_press)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk(clk), .rst_n(rst_n), .btn_n(bus.btn_up_n),
        .stable_n(up_stable_n), .press(up_press)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dw (
        .clk(clk), .rst_n(rst_n), .btn_n(bus.btn_dw_n),
        .stable_n(dw_stable_n), .press(dw_press)
    );

    mode_e         mode_q, mode_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          blank_q, blank_d;
    logic          ena_up_q, ena_up_d;
    logic          ena_dw_q, ena_dw_d;
    logic          timeout;
    logic          mode_change;

    always_comb begin
        timeout = (mode_q != ST_RUN) && (idle_q == IW'(IDLE_CYCLES - 1));

        // Timeout is applied last so it overrides a coincident mode press.
        mode_d = mode_q;
        if (mode_press) mode_d = next_mode(mode_q);
        if (timeout)    mode_d = ST_RUN;

        idle_d = idle_q + IW'(1);
        if (mode_press || up_press || dw_press || mode_q == ST_RUN || timeout) begin
            idle_d = '0;
        end

        // Blank the adjust levels in the change cycle and the one after so a
        // held up/down cannot hit the newly selected field.
        mode_change = (mode_d != mode_q);
        blank_d     = mode_change;

        ena_up_d = 1'b1;
        ena_dw_d = 1'b1;
        if (!mode_change && !blank_q && mode_q != ST_RUN) begin
            // Both held means no action, not up-priority.
            ena_up_d = ~(~up_stable_n & dw_stable_n);
            ena_dw_d = ~(~dw_stable_n & up_stable_n);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q   <= ST_RUN;
            idle_q   <= '0;
            blank_q  <= 1'b0;
            ena_up_q <= 1'b1;
            ena_dw_q <= 1'b1;
        end else begin
            mode_q   <= mode_d;
            idle_q   <= idle_d;
            blank_q  <= blank_d;
            ena_up_q <= ena_up_d;
            ena_dw_q <= ena_dw_d;
        end
    end

    assign bus.select_mode = mode_q;
    assign bus.ena_up      = ena_up_q;
    assign bus.ena_dw      = ena_dw_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_mode_ctrl
// Directed stimulus for clock_mode_ctrl with DEB_CYCLES=4, IDLE_CYCLES=50.
// Stimulus pushes each expected output change {cycle, mode, ena_up, ena_dw}
// into a queue; a monitor samples outputs on the falling edge and, whenever
// they change, pops the next entry and compares value and arrival cycle.
// Inputs are driven on the falling edge; an output registered at rising
// edge N is observed with cyc == N.
// -----------------------------------------------------------------------------
module tb_clock_mode_ctrl;
    import clock_pkg::*;

    localparam int DEB  = 4;
    localparam int IDLE = 50;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   idx    = 0;
    logic mon_en = 1'b0;
    logic [3:0] prev;
    exp_t sb[$];

    clock_mode_ctrl_if bus ();

    clock_mode_ctrl #(.DEB_CYCLES(DEB), .IDLE_CYCLES(IDLE)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [1:0] m, input logic up, input logic dw);
        exp_t e;
        e.cyc = c;
        e.val = {m, up, dw};
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every output change must match the next queued expectation.
    always @(negedge clk) begin
        logic [3:0] cur;
        exp_t       e;
        cur = {bus.select_mode, bus.ena_up, bus.ena_dw};
        if (mon_en && cur !== prev) begin
            if (sb.size() == 0) begin
                check("unexpected_change", {28'd0, cur}, {28'd0, prev});
            end else begin
                e = sb.pop_front();
                check($sformatf("out_%0d", idx), {28'd0, cur}, {28'd0, e.val});
                check($sformatf("cyc_%0d", idx), cyc, e.cyc);
                idx++;
            end
        end
        prev = cur;
    end

    initial begin
        repeat (3000) @(posedge clk);
        $display("FAIL watchdog: bench exceeded 3000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, u, v, w, m, p, r;
        logic [1:0] seq [5];
        seq = '{MODE_SEC, MODE_MIN, MODE_HOUR, MODE_RUN, MODE_SEC};

        // Reset with every button held.
        rst_n          = 1'b0;
        bus.btn_mode_n = 1'b0;
        bus.btn_up_n   = 1'b0;
        bus.btn_dw_n   = 1'b0;
        step(3);
        check("rst_mode", {30'd0, bus.select_mode}, {30'd0, MODE_RUN});
        check("rst_up", {31'd0, bus.ena_up}, 32'd1);
        check("rst_dw", {31'd0, bus.ena_dw}, 32'd1);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        // Held mode accepted after 2 sync + 4 debounce + 1 register; both
        // up and down held so the adjust levels stay inactive.
        t = cyc;
        push(t + 7, MODE_SEC, 1'b1, 1'b1);
        push(t + 57, MODE_RUN, 1'b1, 1'b1);
        wait_until(t + 9);
        bus.btn_mode_n = 1'b1;
        bus.btn_up_n   = 1'b1;
        bus.btn_dw_n   = 1'b1;
        wait_until(t + 60);

        // Five clean mode presses.
        for (int i = 0; i < 5; i++) begin
            t = cyc;
            push(t + 7, seq[i], 1'b1, 1'b1);
            bus.btn_mode_n = 1'b0;
            step(8);
            bus.btn_mode_n = 1'b1;
            step(8);
        end

        // In SEC, hold up for 30 cycles.
        u = cyc;
        push(u + 7, MODE_SEC, 1'b0, 1'b1);
        push(u + 37, MODE_SEC, 1'b1, 1'b1);
        bus.btn_up_n = 1'b0;
        step(30);
        bus.btn_up_n = 1'b1;
        step(10);

        // Down joins a held up: both inactive, then up resumes on down release.
        v = cyc;
        push(v + 7, MODE_SEC, 1'b0, 1'b1);
        push(v + 17, MODE_SEC, 1'b1, 1'b1);
        push(v + 27, MODE_SEC, 1'b0, 1'b1);
        push(v + 37, MODE_SEC, 1'b1, 1'b1);
        bus.btn_up_n = 1'b0;
        step(10);
        bus.btn_dw_n = 1'b0;
        step(10);
        bus.btn_dw_n = 1'b1;
        step(10);
        bus.btn_up_n = 1'b1;
        step(10);

        // Blanking: mode press with up held, then timeout in MIN.
        w = cyc;
        push(w + 7, MODE_SEC, 1'b0, 1'b1);
        bus.btn_up_n = 1'b0;
        step(10);
        m = cyc;
        push(m + 7, MODE_MIN, 1'b1, 1'b1);
        push(m + 9, MODE_MIN, 1'b0, 1'b1);
        push(m + 22, MODE_MIN, 1'b1, 1'b1);
        push(m + 57, MODE_RUN, 1'b1, 1'b1);
        bus.btn_mode_n = 1'b0;
        step(8);
        bus.btn_mode_n = 1'b1;
        step(7);
        bus.btn_up_n = 1'b1;
        wait_until(m + 60);

        // Mode press landing in the timeout cycle still gives RUN.
        p = cyc;
        push(p + 7, MODE_SEC, 1'b1, 1'b1);
        push(p + 57, MODE_RUN, 1'b1, 1'b1);
        bus.btn_mode_n = 1'b0;
        step(8);
        bus.btn_mode_n = 1'b1;
        wait_until(p + 50);
        bus.btn_mode_n = 1'b0;
        step(8);
        bus.btn_mode_n = 1'b1;
        step(10);

        // Up press accepted 40 cycles after entry restarts the idle count.
        r = cyc;
        push(r + 7, MODE_SEC, 1'b1, 1'b1);
        push(r + 47, MODE_SEC, 1'b0, 1'b1);
        push(r + 55, MODE_SEC, 1'b1, 1'b1);
        push(r + 97, MODE_RUN, 1'b1, 1'b1);
        bus.btn_mode_n = 1'b0;
        step(8);
        bus.btn_mode_n = 1'b1;
        wait_until(r + 40);
        bus.btn_up_n = 1'b0;
        step(8);
        bus.btn_up_n = 1'b1;
        wait_until(r + 100);

        // In RUN a held up never asserts ena_up.
        bus.btn_up_n = 1'b0;
        step(15);
        check("run_up_blocked", {31'd0, bus.ena_up}, 32'd1);
        bus.btn_up_n = 1'b1;
        step(10);

        // Bouncing mode button: only the final stable low advances.
        for (int i = 0; i < 5; i++) begin
            bus.btn_mode_n = 1'b0;
            step(2);
            bus.btn_mode_n = 1'b1;
            step(2);
        end
        t = cyc;
        push(t + 7, MODE_SEC, 1'b1, 1'b1);
        push(t + 57, MODE_RUN, 1'b1, 1'b1);
        bus.btn_mode_n = 1'b0;
        step(8);
        bus.btn_mode_n = 1'b1;
        wait_until(t + 62);

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
